// File: rtl/crc16_usb_if.sv
// Serial bit stream into the CRC-16/USB engine and the CRC word back out.
// Transfer rule: crc16_en qualifies crc16_di. A bit is consumed on every
// rising clk edge where crc16_en=1 and reset is low. There is no ready or
// backpressure, because the engine accepts one bit every cycle.
// crc16_di is ignored while crc16_en=0.
interface crc16_usb_if;
  logic        crc16_di;
  logic        crc16_en;
  logic [15:0] crc16_o;
  logic        crc16_ok;

  // Packet engine side: drives bits, reads back the CRC and the residue flag.
  modport master (
    output crc16_di,
    output crc16_en,
    input  crc16_o,
    input  crc16_ok
  );

  // CRC engine side.
  modport slave (
    input  crc16_di,
    input  crc16_en,
    output crc16_o,
    output crc16_ok
  );
endinterface

// File: rtl/crc16_usb.sv
// Bit-serial CRC-16 generator/checker, polynomial x^16+x^15+x^2+1 (USB).
// The internal register r is shifted MSB-first. The outputs depend only on r,
// so crc16_o reflects a bit one clock after that bit is sampled, and no input
// reaches the outputs combinationally.
// The receive check feeds the data bits and then the received CRC bits
// through the same enable. r lands on RESIDUE when the packet is error-free.
module crc16_usb #(
  parameter logic [15:0] POLY    = 16'h8005,
  parameter logic [15:0] INIT    = 16'hFFFF,
  parameter logic [15:0] XOR_OUT = 16'hFFFF,
  parameter logic [15:0] RESIDUE = 16'h800D
) (
  input  logic          clk,
  input  logic          reset_l,  // synchronous, active-high despite the name
  crc16_usb_if.slave    bus
);

  logic [15:0] r;
  logic        fb;

  assign fb = bus.crc16_di ^ r[15];

  // LFSR update: reset has priority, then shift on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset_l) begin
      r <= INIT;
    end else if (bus.crc16_en) begin
      r <= {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
  end

  assign bus.crc16_o  = r ^ XOR_OUT;
  assign bus.crc16_ok = (r == RESIDUE);

endmodule

// File: tb/tb_crc16_usb.sv
// Self-checking bench for crc16_usb.
// The reference model is the standard reflected (LSB-first) CRC-16/USB:
// shift right, reflected polynomial 16'hA001, init 16'hFFFF, final xor
// 16'hFFFF. The expected crc16_o is the bit-reverse of that model's output.
module tb_crc16_usb;

  logic clk = 1'b0;
  logic reset_l;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] ref_crc;          // reflected-domain reference register
  logic [15:0] exp_q[$];         // expected crc16_o per bit in streaming tests
  logic [7:0]  check_str [9];

  crc16_usb_if bus ();

  crc16_usb dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  // Clock and initial input levels.
  always #5 clk = ~clk;

  initial begin
    reset_l      = 1'b0;
    bus.crc16_en = 1'b0;
    bus.crc16_di = 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] o;
    for (int i = 0; i < 16; i++) o[i] = v[15-i];
    return o;
  endfunction

  function automatic logic [15:0] model_out();
    return bitrev16(ref_crc ^ 16'hFFFF);
  endfunction

  function automatic logic model_ok();
    return model_out() == 16'h7FF2;
  endfunction

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs and advances the model the same way.
  task automatic clock_in(input logic rst, input logic en, input logic di);
    reset_l      = rst;
    bus.crc16_en = en;
    bus.crc16_di = di;
    @(posedge clk);
    #1;
    if (rst) begin
      ref_crc = 16'hFFFF;
    end else if (en) begin
      if (ref_crc[0] ^ di) ref_crc = (ref_crc >> 1) ^ 16'hA001;
      else                 ref_crc = ref_crc >> 1;
    end
    reset_l      = 1'b0;
    bus.crc16_en = 1'b0;
  endtask

  task automatic do_reset();
    clock_in(1'b1, 1'b0, 1'b0);
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) clock_in(1'b0, 1'b1, b[i]);
  endtask

  task automatic feed_check_string();
    for (int k = 0; k < 9; k++) feed_byte(check_str[k]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Put state away from INIT first, then reset with en=1, di=1.
    do_reset();
    feed_byte(8'hA5);
    clock_in(1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.crc16_o !== 16'h0000) begin
      failures++;
      $display("FAIL reset_crc: got %h want 0000", bus.crc16_o);
    end
    checks++;
    if (bus.crc16_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_ok: got %b want 0", bus.crc16_ok);
    end
  endtask

  task automatic test_single_bit();
    do_reset();
    clock_in(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.crc16_o !== 16'h8004) begin
      failures++;
      $display("FAIL single_bit0: got %h want 8004", bus.crc16_o);
    end
    do_reset();
    clock_in(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.crc16_o !== 16'h0001) begin
      failures++;
      $display("FAIL single_bit1: got %h want 0001", bus.crc16_o);
    end
  endtask

  task automatic test_check_string();
    do_reset();
    feed_check_string();
    checks++;
    if (bus.crc16_o !== 16'h132D) begin
      failures++;
      $display("FAIL check_string: got %h want 132D", bus.crc16_o);
    end
    checks++;
    if (model_out() !== 16'h132D) begin
      failures++;
      $display("FAIL check_string_model: got %h want 132D", model_out());
    end
  endtask

  task automatic test_enable_gating();
    logic [15:0] held;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) clock_in(1'b0, 1'b0, 1'($urandom));
        clock_in(1'b0, 1'b1, check_str[k][i]);
      end
    end
    checks++;
    if (bus.crc16_o !== 16'h132D) begin
      failures++;
      $display("FAIL enable_gating: got %h want 132D", bus.crc16_o);
    end
    // Long hold with toggling data must not move the state.
    held = bus.crc16_o;
    for (int g = 0; g < 20; g++) clock_in(1'b0, 1'b0, g[0]);
    checks++;
    if (bus.crc16_o !== 16'h132D) begin
      failures++;
      $display("FAIL hold: got %h want 132D (before hold %h)", bus.crc16_o, held);
    end
  endtask

  task automatic test_residual();
    logic [15:0] tx;
    int flip;
    do_reset();
    feed_check_string();
    tx = model_out();
    for (int i = 15; i >= 0; i--) clock_in(1'b0, 1'b1, tx[i]);
    checks++;
    if (bus.crc16_o !== 16'h7FF2) begin
      failures++;
      $display("FAIL residual_crc: got %h want 7FF2", bus.crc16_o);
    end
    checks++;
    if (bus.crc16_ok !== 1'b1) begin
      failures++;
      $display("FAIL residual_ok: got %b want 1", bus.crc16_ok);
    end
    // Any single flipped CRC bit must break the residue.
    for (int n = 0; n < 4; n++) begin
      flip = $urandom_range(0, 15);
      do_reset();
      feed_check_string();
      tx = model_out();
      tx[flip] = ~tx[flip];
      for (int i = 15; i >= 0; i--) clock_in(1'b0, 1'b1, tx[i]);
      checks++;
      if (bus.crc16_ok !== 1'b0) begin
        failures++;
        $display("FAIL residual_flip bit %0d: ok got %b want 0", flip, bus.crc16_ok);
      end
    end
  endtask

  task automatic test_mid_stream_reset();
    do_reset();
    for (int i = 0; i < 40; i++) clock_in(1'b0, 1'b1, 1'($urandom));
    do_reset();
    feed_check_string();
    checks++;
    if (bus.crc16_o !== 16'h132D) begin
      failures++;
      $display("FAIL mid_stream_reset: got %h want 132D", bus.crc16_o);
    end
  endtask

  // Every bit of random streams checked against the model via the queue.
  task automatic test_back_to_back();
    logic [15:0] exp;
    logic        di;
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int i = 0; i < 64; i++) begin
        di = 1'($urandom);
        clock_in(1'b0, 1'b1, di);
        exp_q.push_back(model_out());
        exp = exp_q.pop_front();
        checks++;
        if (bus.crc16_o !== exp) begin
          failures++;
          $display("FAIL back_to_back pkt %0d bit %0d: got %h want %h", p, i, bus.crc16_o, exp);
        end
        checks++;
        if (bus.crc16_ok !== model_ok()) begin
          failures++;
          $display("FAIL back_to_back_ok pkt %0d bit %0d: got %b want %b", p, i, bus.crc16_ok, model_ok());
        end
      end
    end
  endtask

  task automatic test_random_packets();
    logic [15:0] tx;
    int len;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, 12);
      do_reset();
      for (int b = 0; b < len; b++) feed_byte(8'($urandom));
      tx = model_out();
      checks++;
      if (bus.crc16_o !== tx) begin
        failures++;
        $display("FAIL rand_pkt %0d crc: got %h want %h", p, bus.crc16_o, tx);
      end
      for (int i = 15; i >= 0; i--) clock_in(1'b0, 1'b1, tx[i]);
      checks++;
      if (bus.crc16_ok !== 1'b1 || bus.crc16_o !== 16'h7FF2) begin
        failures++;
        $display("FAIL rand_pkt %0d residue: ok %b crc %h want ok 1 crc 7FF2", p, bus.crc16_ok, bus.crc16_o);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ref_crc   = 16'hFFFF;
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_check_string();
    test_enable_gating();
    test_residual();
    test_mid_stream_reset();
    test_back_to_back();
    test_random_packets();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
